// File: rtl/simon_round_sched.sv
// Iterative Simon128/128 encryptor: round FSM, round counter and on-the-fly key schedule.
// Define SIMON_ROUND2_EN to unroll two rounds per clock (half the latency, identical results).
module simon_round_sched #(
    parameter int ROUNDS     = 68,
    parameter int CNT_WIDTH  = 7,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk_simon_block_in,
    input  logic                  rst_simon_block_in,
    input  logic                  key_load,
    input  logic [127:0]          key_i,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out_data,
    output logic                  busy,
    output logic [STAT_WIDTH-1:0] blocks_done
);

    localparam logic [63:0] C  = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
`ifdef SIMON_ROUND2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [127:0]            key_reg;
    logic                    key_valid_reg;
    logic [63:0]             x_reg, y_reg, ka_reg, kb_reg;
    logic [CNT_WIDTH-1:0]    rnd_reg;
    logic [5:0]              zi_reg;
    logic [STAT_WIDTH-1:0]   blocks_done_reg;

    logic                    accept, handoff, last_round;
    logic [5:0]              zi_b, zi_next;
    logic [63:0]             x1, kn1, x_next, y_next, ka_next, kb_next;
`ifdef SIMON_ROUND2_EN
    logic [63:0]             kn2;
`endif

    function automatic logic [63:0] round_f(input logic [63:0] v);
        return ({v[62:0], v[63]} & {v[55:0], v[63:56]}) ^ {v[61:0], v[63:62]};
    endfunction

    function automatic logic [63:0] key_mix(input logic [63:0] ka, input logic [63:0] kb,
                                            input logic zb);
        return C ^ {63'd0, zb} ^ ka ^ {kb[2:0], kb[63:3]} ^ {kb[3:0], kb[63:4]};
    endfunction

    assign in_ready    = key_valid_reg && (state_reg == IDLE || (state_reg == DONE && out_ready));
    assign accept      = in_valid && in_ready;
    assign handoff     = (state_reg == DONE) && out_ready;
    assign last_round  = rnd_reg == CNT_WIDTH'(ROUNDS - STEP);
    assign out_valid   = state_reg == DONE;
    assign busy        = state_reg != IDLE;
    assign out_data    = {x_reg, y_reg};
    assign blocks_done = blocks_done_reg;

    // Round datapath; z2 is stored MSB-first so index i lives at bit 61-i.
    always_comb begin
        zi_b = (zi_reg == 6'd61) ? 6'd0 : zi_reg + 6'd1;
        kn1  = key_mix(ka_reg, kb_reg, Z2[6'd61 - zi_reg]);
        x1   = y_reg ^ round_f(x_reg) ^ ka_reg;
`ifdef SIMON_ROUND2_EN
        kn2     = key_mix(kb_reg, kn1, Z2[6'd61 - zi_b]);
        x_next  = x_reg ^ round_f(x1) ^ kb_reg;
        y_next  = x1;
        ka_next = kn1;
        kb_next = kn2;
        zi_next = (zi_b == 6'd61) ? 6'd0 : zi_b + 6'd1;
`else
        x_next  = x1;
        y_next  = x_reg;
        ka_next = kb_reg;
        kb_next = kn1;
        zi_next = zi_b;
`endif
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (last_round) state_next = DONE;
            DONE: if (out_ready) state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_simon_block_in) begin
        if (rst_simon_block_in) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The accepting block reads key_reg before a same-edge key_load updates it.
    always_ff @(posedge clk_simon_block_in) begin
        if (rst_simon_block_in) begin
            key_reg         <= '0;
            key_valid_reg   <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            ka_reg          <= '0;
            kb_reg          <= '0;
            rnd_reg         <= '0;
            zi_reg          <= '0;
            blocks_done_reg <= '0;
        end else begin
            if (key_load) begin
                key_reg       <= key_i;
                key_valid_reg <= 1'b1;
            end
            if (accept) begin
                x_reg   <= in_data[127:64];
                y_reg   <= in_data[63:0];
                ka_reg  <= key_reg[63:0];
                kb_reg  <= key_reg[127:64];
                rnd_reg <= '0;
                zi_reg  <= '0;
            end else if (state_reg == RUN) begin
                x_reg   <= x_next;
                y_reg   <= y_next;
                ka_reg  <= ka_next;
                kb_reg  <= kb_next;
                rnd_reg <= rnd_reg + CNT_WIDTH'(STEP);
                zi_reg  <= zi_next;
            end
            if (handoff) begin
                blocks_done_reg <= blocks_done_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_simon_round_sched.sv
// Directed testbench for simon_round_sched: known answer, no-key, backpressure,
// back-to-back, key change, same-edge key load and mid-run reset.
module tb_simon_round_sched;

`ifdef SIMON_ROUND2_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 68;
`endif
    localparam logic [127:0] KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] PT  = 128'h63736564_20737265_6c6c6576_61727420;
    localparam logic [127:0] CT  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;
    localparam logic [61:0]  ZSEQ = 62'b10101111011100000011010010011000101000010001111110010110110011;

    logic         clk = 1'b0;
    logic         srst = 1'b0;
    logic         key_load = 1'b0;
    logic [127:0] key_i = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;
    logic [31:0]  blocks_done;

    int checks = 0;
    int errors = 0;
    logic [31:0] bd_exp = 0;

    simon_round_sched dut (
        .clk_simon_block_in (clk),
        .rst_simon_block_in (srst),
        .key_load           (key_load),
        .key_i              (key_i),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_data            (in_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .busy               (busy),
        .blocks_done        (blocks_done)
    );

    always #5 clk = ~clk;

    // Reference: expand all round keys first, then run the Feistel rounds.
    function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [127:0] simon_ref(input logic [127:0] k, input logic [127:0] p);
        logic [63:0] rk [0:67];
        logic [63:0] x, y, t;
        logic [61:0] zs;
        zs = ZSEQ;
        rk[0] = k[63:0];
        rk[1] = k[127:64];
        for (int i = 0; i < 66; i++) begin
            rk[i+2] = 64'hFFFF_FFFF_FFFF_FFFC ^ {63'd0, zs[61 - (i % 62)]} ^ rk[i]
                      ^ rotr(rk[i+1], 3) ^ rotr(rk[i+1], 4);
        end
        x = p[127:64];
        y = p[63:0];
        for (int i = 0; i < 68; i++) begin
            t = x;
            x = y ^ (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2) ^ rk[i];
            y = t;
        end
        return {x, y};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        key_i = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
    endtask

    // Present a block and wait (bounded) for the accepting edge.
    task automatic send(input logic [127:0] d, input logic kl, input logic [127:0] k,
                        output logic ok);
        in_valid = 1'b1;
        in_data = d;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            else step();
        end
        if (ok) begin
            key_load = kl;
            key_i = k;
            step();
            key_load = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 300) begin
            step();
            n++;
        end
        if (!out_valid) n = -1;
        else $display("block out data=%h after %0d clocks", out_data, n);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        bd_exp = bd_exp + 1;
    endtask

    task automatic test_reset();
        srst = 1'b1;
        step();
        step();
        srst = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (out_data !== 128'd0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (blocks_done !== 32'd0) begin errors++; $display("FAIL reset_blocks_done got %0d want 0", blocks_done); end
        bd_exp = 0;
    endtask

    task automatic test_no_key();
        in_valid = 1'b1;
        in_data = PT;
        for (int i = 0; i < 100; i++) begin
            step();
            checks++;
            if ({in_ready, out_valid, busy} !== 3'b000) begin
                errors++;
                $display("FAIL no_key cycle %0d ready/valid/busy got %b want 000", i, {in_ready, out_valid, busy});
            end
        end
        in_valid = 1'b0;
        $display("no-key window of 100 cycles done");
    endtask

    task automatic test_kat();
        logic ok;
        int n;
        load_key(KEY);
        send(PT, 1'b0, '0, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL kat_accept got %b want 1", ok); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL kat_busy got %b want 1", busy); end
        wait_out(n);
        checks++; if (n != LAT) begin errors++; $display("FAIL kat_latency got %0d want %0d", n, LAT); end
        checks++; if (out_data !== CT) begin errors++; $display("FAIL kat_data got %h want %h", out_data, CT); end
        handshake();
        checks++; if (blocks_done !== bd_exp) begin errors++; $display("FAIL kat_blocks_done got %0d want %0d", blocks_done, bd_exp); end
        checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL kat_idle valid/busy got %b want 00", {out_valid, busy}); end
    endtask

    task automatic test_backpressure();
        logic ok;
        int n;
        logic [31:0] bd0;
        send(PT, 1'b0, '0, ok);
        wait_out(n);
        bd0 = blocks_done;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (out_data !== CT || in_ready !== 1'b0 || out_valid !== 1'b1 || blocks_done !== bd0) begin
                errors++;
                $display("FAIL bp cycle %0d data=%h ready=%b valid=%b done=%0d want %h 0 1 %0d",
                         i, out_data, in_ready, out_valid, blocks_done, CT, bd0);
            end
            step();
        end
        in_valid = 1'b0;
        handshake();
        checks++; if (blocks_done !== bd0 + 1) begin errors++; $display("FAIL bp_blocks_done got %0d want %0d", blocks_done, bd0 + 1); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic ok;
        int n;
        out_ready = 1'b1;
        send(PT, 1'b0, '0, ok);
        in_valid = 1'b1;
        in_data = PT;
        wait_out(n);
        checks++; if (out_data !== CT) begin errors++; $display("FAIL b2b_first_data got %h want %h", out_data, CT); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_same_edge_ready got %b want 1", in_ready); end
        step();
        bd_exp = bd_exp + 1;
        checks++; if ({out_valid, busy} !== 2'b01) begin errors++; $display("FAIL b2b_rerun valid/busy got %b want 01", {out_valid, busy}); end
        checks++; if (blocks_done !== bd_exp) begin errors++; $display("FAIL b2b_done1 got %0d want %0d", blocks_done, bd_exp); end
        wait_out(n);
        checks++; if (n != LAT) begin errors++; $display("FAIL b2b_latency got %0d want %0d", n, LAT); end
        checks++; if (out_data !== CT) begin errors++; $display("FAIL b2b_second_data got %h want %h", out_data, CT); end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        bd_exp = bd_exp + 1;
        checks++; if (blocks_done !== bd_exp) begin errors++; $display("FAIL b2b_done2 got %0d want %0d", blocks_done, bd_exp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle busy got %b want 0", busy); end
    endtask

    task automatic test_key_change();
        logic ok;
        int n;
        logic [127:0] want0;
        want0 = simon_ref(128'd0, PT);
        send(PT, 1'b0, '0, ok);
        for (int i = 0; i < 10; i++) step();
        load_key(128'd0);
        wait_out(n);
        checks++; if (out_data !== CT) begin errors++; $display("FAIL keychg_old_key got %h want %h", out_data, CT); end
        handshake();
        send(PT, 1'b0, '0, ok);
        wait_out(n);
        checks++; if (out_data !== want0) begin errors++; $display("FAIL keychg_zero_key got %h want %h", out_data, want0); end
        handshake();
    endtask

    task automatic test_key_same_edge();
        logic ok;
        int n;
        logic [127:0] want0;
        want0 = simon_ref(128'd0, PT);
        send(PT, 1'b1, KEY, ok);
        wait_out(n);
        checks++; if (out_data !== want0) begin errors++; $display("FAIL same_edge_prev_key got %h want %h", out_data, want0); end
        handshake();
        send(PT, 1'b0, '0, ok);
        wait_out(n);
        checks++; if (out_data !== CT) begin errors++; $display("FAIL same_edge_new_key got %h want %h", out_data, CT); end
        handshake();
        checks++; if (blocks_done !== bd_exp) begin errors++; $display("FAIL same_edge_done got %0d want %0d", blocks_done, bd_exp); end
    endtask

    task automatic test_reset_mid();
        logic ok;
        send(PT, 1'b0, '0, ok);
        for (int i = 0; i < 30; i++) step();
        srst = 1'b1;
        step();
        srst = 1'b0;
        bd_exp = 0;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b000 || out_data !== 128'd0 || blocks_done !== 32'd0) begin
            errors++;
            $display("FAIL midreset ready/valid/busy=%b data=%h done=%0d want 000 0 0",
                     {in_ready, out_valid, busy}, out_data, blocks_done);
        end
        in_valid = 1'b1;
        in_data = PT;
        for (int i = 0; i < LAT + 20; i++) begin
            step();
            checks++;
            if ({in_ready, out_valid, busy} !== 3'b000 || blocks_done !== 32'd0) begin
                errors++;
                $display("FAIL midreset_after cycle %0d ready/valid/busy=%b done=%0d want 000 0",
                         i, {in_ready, out_valid, busy}, blocks_done);
            end
        end
        in_valid = 1'b0;
        $display("mid-run reset window done");
    endtask

    initial begin
        step();
        test_reset();
        test_no_key();
        test_kat();
        test_backpressure();
        test_back_to_back();
        test_key_change();
        test_key_same_edge();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
